// File: rtl/ushift_pkg.sv
// Shared types for the universal shift register: command opcodes and FSM states.
// Used by univ_shift_reg and ushift_step (build option USHIFT_BARREL_EN lives in the top).
package ushift_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_ASR  = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(op_e op);
    return (op != OP_NOP) && (op != OP_LOAD) && (op != OP_CLR);
  endfunction

endpackage

// File: rtl/ushift_step.sv
// One-bit shift/rotate step: applies a single shift of the selected op to d.
// Non-shift opcodes pass d through unchanged with out_bit=0.
module ushift_step
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic             fill,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_next,
  output logic             out_bit
);

  always_comb begin
    d_next  = d;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        d_next  = {d[WIDTH-2:0], fill};
        out_bit = d[WIDTH-1];
      end
      OP_SHR: begin
        d_next  = {fill, d[WIDTH-1:1]};
        out_bit = d[0];
      end
      OP_ROL: begin
        d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
        out_bit = d[WIDTH-1];
      end
      OP_ROR: begin
        d_next  = {d[0], d[WIDTH-1:1]};
        out_bit = d[0];
      end
      OP_ASR: begin
        d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
        out_bit = d[0];
      end
      default: begin
        d_next  = d;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with valid/ready command port; shifts iterate 1 bit/cycle.
// Define USHIFT_BARREL_EN to complete every shift in the accept edge instead.
module univ_shift_reg
  import ushift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is low only while an iterative shift is running, and a command
  // presented then is dropped, not queued.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;
  op_e              op_q, op_d;
  logic             fill_q, fill_d;
  logic [AMT_W-1:0] rem_q, rem_d;

  op_e              cmd_op_e;
  logic             accept;
  op_e              step_op;
  logic             step_fill;
  logic [WIDTH-1:0] step_d;
  logic             step_out;

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // In IDLE the step sees the incoming command so the first bit lands on the accept edge.
  assign step_op   = (state_q == SHIFT) ? op_q   : cmd_op_e;
  assign step_fill = (state_q == SHIFT) ? fill_q : ser_in;

  ushift_step #(.WIDTH(WIDTH)) u_step (
    .op      (step_op),
    .fill    (step_fill),
    .d       (data_q),
    .d_next  (step_d),
    .out_bit (step_out)
  );

`ifdef USHIFT_BARREL_EN
  logic [WIDTH-1:0] chain_d   [WIDTH];
  logic             chain_out [WIDTH];

  assign chain_d[0]   = data_q;
  assign chain_out[0] = ser_q;

  // Tap k of the cascade holds the result of k single steps and the last bit out.
  for (genvar k = 1; k < WIDTH; k++) begin : g_chain
    ushift_step #(.WIDTH(WIDTH)) u_bstep (
      .op      (cmd_op_e),
      .fill    (ser_in),
      .d       (chain_d[k-1]),
      .d_next  (chain_d[k]),
      .out_bit (chain_out[k])
    );
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= OP_NOP;
      fill_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    op_d    = op_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = cmd_op_e;
          fill_d = ser_in;
          if (!is_shift_op(cmd_op_e)) begin
            done_d = 1'b1;
            if (cmd_op_e == OP_LOAD) data_d = load_data;
            if (cmd_op_e == OP_CLR)  data_d = '0;
          end else if (cmd_amt == '0) begin
            done_d = 1'b1;
          end else begin
`ifdef USHIFT_BARREL_EN
            data_d = chain_d[cmd_amt];
            ser_d  = chain_out[cmd_amt];
            done_d = 1'b1;
`else
            data_d = step_d;
            ser_d  = step_out;
            if (cmd_amt == AMT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = SHIFT;
              rem_d   = cmd_amt - AMT_W'(1);
            end
`endif
          end
        end
      end
      SHIFT: begin
        data_d = step_d;
        ser_d  = step_out;
        rem_d  = rem_q - AMT_W'(1);
        if (rem_q == AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign ser_out   = ser_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
